// File: rtl/bus_datapath_pkg.sv
// Shared definitions for the single-bus datapath.
// Source/destination offsets are relative to NREGS: bit NREGS+SRC_x of
// out_en selects special source x, and bit NREGS+DST_x of in_en loads
// special register x.
package bus_datapath_pkg;

  // Bus sources following the GPR selects
  localparam int unsigned SRC_HI     = 0;
  localparam int unsigned SRC_LO     = 1;
  localparam int unsigned SRC_ZHI    = 2;
  localparam int unsigned SRC_ZLO    = 3;
  localparam int unsigned SRC_PC     = 4;
  localparam int unsigned SRC_MDR    = 5;
  localparam int unsigned SRC_INPORT = 6;
  localparam int unsigned SRC_Y      = 7;
  localparam int unsigned SRC_C      = 8;

  // Load destinations following the GPR enables
  localparam int unsigned DST_HI      = 0;
  localparam int unsigned DST_LO      = 1;
  localparam int unsigned DST_Z       = 2;
  localparam int unsigned DST_PC      = 3;
  localparam int unsigned DST_MDR     = 4;
  localparam int unsigned DST_IR      = 5;
  localparam int unsigned DST_MAR     = 6;
  localparam int unsigned DST_Y       = 7;
  localparam int unsigned DST_OUTPORT = 8;

  localparam int unsigned NSPECIAL = 9;

  // Widest select vector count_ones accepts (NREGS + NSPECIAL must fit)
  localparam int unsigned SEL_MAX = 128;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_WAIT = 2'd2
  } mem_state_e;

  // Number of asserted bus-source selects
  function automatic int unsigned count_ones(input logic [SEL_MAX-1:0] v);
    return unsigned'($countones(v));
  endfunction

endpackage

// File: rtl/bus_datapath_p_mem_handshake_fsm.sv
// Memory req/ack handshake with wait-state timeout.
// Ports:
//   i_clk, i_rst_n         clock, async active-low reset
//   i_rd_start, i_wr_start single-cycle transaction requests
//   i_ack                  memory completion
//   i_addr, i_wdata        MAR/MDR values latched when a transaction starts
//   o_mem_req, o_mem_we    handshake outputs
//   o_mem_addr, o_mem_wdata latched address/data, stable while busy
//   o_busy                 transaction in flight
//   o_rd_done              read accepted this cycle (MDR captures rdata)
//   o_proto_evt            protocol violation seen this cycle
//   o_mem_err              sticky timeout flag
module mem_handshake_fsm
  import bus_datapath_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned AW      = 9,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_rd_start,
  input  logic             i_wr_start,
  input  logic             i_ack,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic             o_mem_req,
  output logic             o_mem_we,
  output logic [AW-1:0]    o_mem_addr,
  output logic [WIDTH-1:0] o_mem_wdata,
  output logic             o_busy,
  output logic             o_rd_done,
  output logic             o_proto_evt,
  output logic             o_mem_err
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  mem_state_e       r_state, w_next;
  logic             r_we;
  logic [AW-1:0]    r_addr;
  logic [WIDTH-1:0] r_wdata;
  logic [CW-1:0]    r_cnt;
  logic             r_mem_err;

  logic w_idle, w_start, w_done, w_timeout;

  assign w_idle    = (r_state == MEM_IDLE);
  assign w_start   = i_rd_start | i_wr_start;
  // An ack is only accepted once the request is already on the wire
  assign w_done    = ~w_idle & i_ack;
  // r_cnt counts busy cycles from REQ entry; ack on the final cycle still wins
  assign w_timeout = ~w_idle & ~i_ack & (r_cnt == CW'(TIMEOUT - 1));

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      MEM_IDLE: if (w_start) w_next = MEM_REQ;
      MEM_REQ, MEM_WAIT: begin
        if (w_done || w_timeout) w_next = MEM_IDLE;
        else                     w_next = MEM_WAIT;
      end
      default: w_next = MEM_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= MEM_IDLE;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_cnt     <= '0;
      r_mem_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_idle && w_start) begin
        r_we    <= ~i_rd_start;
        r_addr  <= i_addr;
        r_wdata <= i_wdata;
        r_cnt   <= '0;
      end else if (!w_idle && !w_done && !w_timeout) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_timeout) r_mem_err <= 1'b1;
    end
  end

  assign o_busy      = ~w_idle;
  assign o_mem_req   = ~w_idle;
  assign o_mem_we    = ~w_idle & r_we;
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;
  assign o_rd_done   = w_done & ~r_we;
  assign o_mem_err   = r_mem_err;
  assign o_proto_evt = (w_idle & i_rd_start & i_wr_start)
                     | (w_idle & i_ack)
                     | (~w_idle & w_start);

endmodule

// File: rtl/bus_datapath_p.sv
// Single-bus CPU datapath: GPR file, special registers, one shared bus and
// a req/ack memory port. The ALU is external: Y and the bus go out,
// the 2*WIDTH result comes back into Z.
// Ports:
//   Clock, clr_n           clock, async active-low reset
//   out_en                 one-hot bus source select (GPRs, then HI..C)
//   in_en                  load enables (GPRs, then HI..OUTPORT)
//   BAout                  R0 reads as zero on the bus
//   c_sext                 constant source
//   inport_data            sampled into INPORT every cycle
//   alu_result             Z load data
//   inc_pc                 PC += PC_STEP (beats a bus load of PC)
//   mem_rd_start/wr_start  transaction requests; mem_ack/mem_rdata response
//   bus, y_q, ir_q, outport_q  observed values
//   mem_req/we/addr/wdata/busy memory interface
//   bus_err, mem_err, proto_err sticky error flags
module bus_datapath_p
  import bus_datapath_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NREGS   = 16,
  parameter int unsigned AW      = 9,
  parameter int unsigned PC_STEP = 1,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                      Clock,
  input  logic                      clr_n,
  input  logic [NREGS+NSPECIAL-1:0] out_en,
  input  logic [NREGS+NSPECIAL-1:0] in_en,
  input  logic                      BAout,
  input  logic [WIDTH-1:0]          c_sext,
  input  logic [WIDTH-1:0]          inport_data,
  input  logic [2*WIDTH-1:0]        alu_result,
  input  logic                      inc_pc,
  input  logic                      mem_rd_start,
  input  logic                      mem_wr_start,
  input  logic                      mem_ack,
  input  logic [WIDTH-1:0]          mem_rdata,
  output logic [WIDTH-1:0]          bus,
  output logic [WIDTH-1:0]          y_q,
  output logic [WIDTH-1:0]          ir_q,
  output logic [WIDTH-1:0]          outport_q,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [AW-1:0]             mem_addr,
  output logic [WIDTH-1:0]          mem_wdata,
  output logic                      mem_busy,
  output logic                      bus_err,
  output logic                      mem_err,
  output logic                      proto_err
);

  logic [WIDTH-1:0] r_hi, r_lo, r_zhi, r_zlo, r_pc, r_mdr;
  logic [WIDTH-1:0] r_ir, r_y, r_outport, r_inport;
  logic [AW-1:0]    r_mar;
  logic             r_bus_err, r_proto_err;

  logic [WIDTH-1:0] w_gpr_or [NREGS+1];
  logic [WIDTH-1:0] w_src, w_bus;
  int unsigned      w_nsrc;
  logic             w_rd_done, w_proto_evt;

  // GPR file; each register contributes to an OR chain feeding the bus
  assign w_gpr_or[0] = '0;
  for (genvar g = 0; g < NREGS; g++) begin : g_gpr
    logic [WIDTH-1:0] r_q;
    always_ff @(posedge Clock or negedge clr_n) begin
      if (!clr_n)        r_q <= '0;
      else if (in_en[g]) r_q <= w_bus;
    end
    assign w_gpr_or[g+1] = w_gpr_or[g]
                         | ((out_en[g] && !(g == 0 && BAout)) ? r_q : '0);
  end

  // AND-OR mux; only trusted when exactly one select is high
  always_comb begin
    w_src = w_gpr_or[NREGS];
    if (out_en[NREGS+SRC_HI])     w_src = w_src | r_hi;
    if (out_en[NREGS+SRC_LO])     w_src = w_src | r_lo;
    if (out_en[NREGS+SRC_ZHI])    w_src = w_src | r_zhi;
    if (out_en[NREGS+SRC_ZLO])    w_src = w_src | r_zlo;
    if (out_en[NREGS+SRC_PC])     w_src = w_src | r_pc;
    if (out_en[NREGS+SRC_MDR])    w_src = w_src | r_mdr;
    if (out_en[NREGS+SRC_INPORT]) w_src = w_src | r_inport;
    if (out_en[NREGS+SRC_Y])      w_src = w_src | r_y;
    if (out_en[NREGS+SRC_C])      w_src = w_src | c_sext;
  end

  assign w_nsrc = count_ones(SEL_MAX'(out_en));
  assign w_bus  = (w_nsrc == 1) ? w_src : '0;

  always_ff @(posedge Clock or negedge clr_n) begin
    if (!clr_n) begin
      r_hi        <= '0;
      r_lo        <= '0;
      r_zhi       <= '0;
      r_zlo       <= '0;
      r_pc        <= '0;
      r_mdr       <= '0;
      r_ir        <= '0;
      r_mar       <= '0;
      r_y         <= '0;
      r_outport   <= '0;
      r_inport    <= '0;
      r_bus_err   <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      r_inport <= inport_data;
      if (in_en[NREGS+DST_HI])      r_hi      <= w_bus;
      if (in_en[NREGS+DST_LO])      r_lo      <= w_bus;
      if (in_en[NREGS+DST_Z]) begin
        r_zhi <= alu_result[2*WIDTH-1:WIDTH];
        r_zlo <= alu_result[WIDTH-1:0];
      end
      if (inc_pc)                   r_pc      <= r_pc + WIDTH'(PC_STEP);
      else if (in_en[NREGS+DST_PC]) r_pc      <= w_bus;
      if (w_rd_done)                r_mdr     <= mem_rdata;
      else if (in_en[NREGS+DST_MDR]) r_mdr    <= w_bus;
      if (in_en[NREGS+DST_IR])      r_ir      <= w_bus;
      if (in_en[NREGS+DST_MAR])     r_mar     <= w_bus[AW-1:0];
      if (in_en[NREGS+DST_Y])       r_y       <= w_bus;
      if (in_en[NREGS+DST_OUTPORT]) r_outport <= w_bus;
      if (w_nsrc > 1)               r_bus_err <= 1'b1;
      if (w_proto_evt || (w_rd_done && in_en[NREGS+DST_MDR]))
        r_proto_err <= 1'b1;
    end
  end

  mem_handshake_fsm #(
    .WIDTH   (WIDTH),
    .AW      (AW),
    .TIMEOUT (TIMEOUT)
  ) u_mem (
    .i_clk       (Clock),
    .i_rst_n     (clr_n),
    .i_rd_start  (mem_rd_start),
    .i_wr_start  (mem_wr_start),
    .i_ack       (mem_ack),
    .i_addr      (r_mar),
    .i_wdata     (r_mdr),
    .o_mem_req   (mem_req),
    .o_mem_we    (mem_we),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .o_busy      (mem_busy),
    .o_rd_done   (w_rd_done),
    .o_proto_evt (w_proto_evt),
    .o_mem_err   (mem_err)
  );

  assign bus       = w_bus;
  assign y_q       = r_y;
  assign ir_q      = r_ir;
  assign outport_q = r_outport;
  assign bus_err   = r_bus_err;
  assign proto_err = r_proto_err;

endmodule

// File: tb/tb_bus_datapath_p.sv
module tb_bus_datapath_p;

  localparam int W       = 32;
  localparam int NR      = 16;
  localparam int NS      = NR + 9;
  localparam int AWID    = 9;
  localparam int TIMEOUT = 15;

  logic            Clock = 1'b0;
  logic            clr_n;
  logic [NS-1:0]   out_en, in_en;
  logic            BAout, inc_pc, mem_rd_start, mem_wr_start, mem_ack;
  logic [W-1:0]    c_sext, inport_data, mem_rdata;
  logic [2*W-1:0]  alu_result;
  logic [W-1:0]    bus, y_q, ir_q, outport_q, mem_wdata;
  logic            mem_req, mem_we, mem_busy, bus_err, mem_err, proto_err;
  logic [AWID-1:0] mem_addr;

  bus_datapath_p #(
    .WIDTH   (W),
    .NREGS   (NR),
    .AW      (AWID),
    .PC_STEP (1),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .Clock        (Clock),
    .clr_n        (clr_n),
    .out_en       (out_en),
    .in_en        (in_en),
    .BAout        (BAout),
    .c_sext       (c_sext),
    .inport_data  (inport_data),
    .alu_result   (alu_result),
    .inc_pc       (inc_pc),
    .mem_rd_start (mem_rd_start),
    .mem_wr_start (mem_wr_start),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .bus          (bus),
    .y_q          (y_q),
    .ir_q         (ir_q),
    .outport_q    (outport_q),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_busy     (mem_busy),
    .bus_err      (bus_err),
    .mem_err      (mem_err),
    .proto_err    (proto_err)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [W-1:0]    bus, y, ir, outp, wdata;
    logic [AWID-1:0] addr;
    logic            req, we, busy, berr, merr, perr;
  } exp_t;

  exp_t q_exp[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Reference state: architectural registers and transaction bookkeeping
  logic [W-1:0]    m_gpr [NR];
  logic [W-1:0]    m_hi, m_lo, m_zhi, m_zlo, m_pc, m_mdr, m_ir, m_y, m_out, m_inport;
  logic [AWID-1:0] m_mar, m_addr;
  logic [W-1:0]    m_wdata;
  logic            m_busy, m_we, m_berr, m_merr, m_perr;
  int              m_k;

  function automatic logic [NS-1:0] bit_of(input int i);
    logic [NS-1:0] m;
    m    = '0;
    m[i] = 1'b1;
    return m;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_gpr[i] = '0;
    m_hi = '0; m_lo = '0; m_zhi = '0; m_zlo = '0; m_pc = '0; m_mdr = '0;
    m_ir = '0; m_y = '0; m_out = '0; m_inport = '0; m_mar = '0;
    m_addr = '0; m_wdata = '0; m_busy = 0; m_we = 0;
    m_berr = 0; m_merr = 0; m_perr = 0; m_k = 0;
  endtask

  function automatic logic [W-1:0] model_bus();
    int idx;
    idx = 0;
    if ($countones(out_en) != 1) return '0;
    for (int i = 0; i < NS; i++) if (out_en[i]) idx = i;
    if (idx < NR) return (idx == 0 && BAout) ? '0 : m_gpr[idx];
    case (idx - NR)
      0: return m_hi;
      1: return m_lo;
      2: return m_zhi;
      3: return m_zlo;
      4: return m_pc;
      5: return m_mdr;
      6: return m_inport;
      7: return m_y;
      default: return c_sext;
    endcase
  endfunction

  task automatic model_edge();
    logic [W-1:0] b;
    logic rd_done;
    if (!clr_n) begin
      model_reset();
      return;
    end
    b = model_bus();
    rd_done = 0;
    if ($countones(out_en) > 1) m_berr = 1;
    if (!m_busy) begin
      if (mem_ack) m_perr = 1;
      if (mem_rd_start || mem_wr_start) begin
        if (mem_rd_start && mem_wr_start) m_perr = 1;
        m_busy = 1; m_k = 0; m_we = !mem_rd_start;
        m_addr = m_mar; m_wdata = m_mdr;
      end
    end else begin
      if (mem_rd_start || mem_wr_start) m_perr = 1;
      m_k++;
      if (mem_ack) begin
        m_busy = 0;
        if (!m_we) rd_done = 1;
      end else if (m_k == TIMEOUT) begin
        m_busy = 0;
        m_merr = 1;
      end
    end
    for (int i = 0; i < NR; i++) if (in_en[i]) m_gpr[i] = b;
    if (in_en[NR+0]) m_hi = b;
    if (in_en[NR+1]) m_lo = b;
    if (in_en[NR+2]) {m_zhi, m_zlo} = alu_result;
    if (inc_pc) m_pc = m_pc + 1;
    else if (in_en[NR+3]) m_pc = b;
    if (in_en[NR+4]) m_mdr = b;
    if (in_en[NR+5]) m_ir = b;
    if (in_en[NR+6]) m_mar = b[AWID-1:0];
    if (in_en[NR+7]) m_y = b;
    if (in_en[NR+8]) m_out = b;
    if (rd_done) begin
      if (in_en[NR+4]) m_perr = 1;
      m_mdr = mem_rdata;
    end
    m_inport = inport_data;
  endtask

  // Queue the expected view of the current cycle, then advance one edge
  task automatic cycle();
    exp_t e;
    e.bus = model_bus(); e.y = m_y; e.ir = m_ir; e.outp = m_out;
    e.req = m_busy; e.we = m_busy && m_we; e.busy = m_busy;
    e.addr = m_addr; e.wdata = m_wdata;
    e.berr = m_berr; e.merr = m_merr; e.perr = m_perr;
    q_exp.push_back(e);
    @(posedge Clock);
    model_edge();
    #1;
  endtask

  task automatic defaults();
    out_en = '0; in_en = '0; BAout = 0; inc_pc = 0;
    mem_rd_start = 0; mem_wr_start = 0; mem_ack = 0;
    c_sext = $urandom; inport_data = $urandom; mem_rdata = $urandom;
    alu_result = {$urandom, $urandom};
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every queued expectation at the falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge Clock);
      while (q_exp.size() > 0) begin
        e = q_exp.pop_front();
        chk("bus", 64'(bus), 64'(e.bus));
        chk("y_q", 64'(y_q), 64'(e.y));
        chk("ir_q", 64'(ir_q), 64'(e.ir));
        chk("outport_q", 64'(outport_q), 64'(e.outp));
        chk("mem_req", 64'(mem_req), 64'(e.req));
        chk("mem_we", 64'(mem_we), 64'(e.we));
        chk("mem_busy", 64'(mem_busy), 64'(e.busy));
        chk("bus_err", 64'(bus_err), 64'(e.berr));
        chk("mem_err", 64'(mem_err), 64'(e.merr));
        chk("proto_err", 64'(proto_err), 64'(e.perr));
        if (e.busy) begin
          chk("mem_addr", 64'(mem_addr), 64'(e.addr));
          chk("mem_wdata", 64'(mem_wdata), 64'(e.wdata));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    clr_n = 1'b0;
    defaults();
    model_reset();
    @(posedge Clock); #1;
    cycle();
    cycle();
    clr_n = 1'b1;

    // R3 = DEADBEEF, then R3 -> Y
    defaults(); out_en = bit_of(NR+8); c_sext = 32'hDEADBEEF; in_en = bit_of(3); cycle();
    defaults(); out_en = bit_of(3); in_en = bit_of(NR+7); cycle();
    defaults(); cycle();

    // Two sources at once: bus zero, bus_err sticky
    defaults(); out_en = bit_of(3) | bit_of(NR+4); cycle();
    repeat (10) begin defaults(); cycle(); end

    // BAout masks R0
    defaults(); out_en = bit_of(NR+8); c_sext = 32'h5; in_en = bit_of(0); cycle();
    defaults(); out_en = bit_of(0); BAout = 1; cycle();
    defaults(); out_en = bit_of(0); BAout = 0; cycle();

    // Wait-state read of 0x1A5, ack on the 4th edge after the start
    defaults(); out_en = bit_of(NR+8); c_sext = 32'h1A5; in_en = bit_of(NR+6); cycle();
    defaults(); mem_rd_start = 1; cycle();
    repeat (3) begin defaults(); cycle(); end
    defaults(); mem_ack = 1; mem_rdata = 32'h1234; cycle();
    defaults(); out_en = bit_of(NR+5); in_en = bit_of(NR+7); cycle();
    defaults(); cycle();

    // Write with no ack: timeout; a start while busy flags a protocol error
    defaults(); mem_wr_start = 1; cycle();
    defaults(); cycle();
    defaults(); mem_rd_start = 1; cycle();
    repeat (15) begin defaults(); cycle(); end

    // inc_pc beats a bus load of PC
    defaults(); out_en = bit_of(NR+8); c_sext = 32'h10; in_en = bit_of(NR+3); cycle();
    defaults(); out_en = bit_of(NR+8); c_sext = 32'h99; in_en = bit_of(NR+3); inc_pc = 1; cycle();
    defaults(); out_en = bit_of(NR+4); in_en = bit_of(NR+7); cycle();
    defaults(); cycle();

    // Reset in the middle of a read, observed before the next edge
    defaults(); out_en = bit_of(NR+8); c_sext = 32'hCAFE0001; in_en = bit_of(NR+4); cycle();
    defaults(); mem_rd_start = 1; cycle();
    defaults(); cycle();
    defaults(); cycle();
    defaults(); out_en = bit_of(NR+5); clr_n = 1'b0; model_reset(); cycle();
    defaults(); cycle();
    clr_n = 1'b1;

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      int r;
      defaults();
      r = $urandom_range(0, 19);
      if (r == 0)      out_en = '0;
      else if (r == 1) out_en = bit_of($urandom_range(0, NS-1)) | bit_of($urandom_range(0, NS-1));
      else             out_en = bit_of($urandom_range(0, NS-1));
      for (int i = 0; i < NS; i++) in_en[i] = ($urandom_range(0, 7) == 0);
      BAout        = ($urandom_range(0, 3) == 0);
      inc_pc       = ($urandom_range(0, 7) == 0);
      mem_rd_start = ($urandom_range(0, 9) == 0);
      mem_wr_start = ($urandom_range(0, 9) == 0);
      mem_ack      = ($urandom_range(0, 3) == 0);
      cycle();
    end

    defaults();
    @(negedge Clock); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
